hiscore_ram_arbiter: RTL and testbench

HISCORE_RAM_ARBITER -- requirements
Module: hiscore_ram_arbiter

---
 rtl/hiscore_pkg.sv | 20 ++
 rtl/hiscore_delay_counter.sv | 40 ++++
 rtl/hiscore_ram_arbiter.sv | 159 +++++++++++++++
 tb/tb_hiscore_ram_arbiter.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hiscore_pkg.sv
// hiscore_pkg: shared state type and default timing constants
// for the hiscore RAM arbiter and its delay counters.
package hiscore_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAUSE_REQ,
    ST_SETTLE,
    ST_GRANT,
    ST_RELEASE
  } hs_state_e;

  localparam int DEF_PAUSE_SETTLE = 4;
  localparam int DEF_LINGER       = 8;
  localparam int DEF_MAX_HOLD     = 1023;

  // Wide enough for every default limit; counts saturate at all-ones.
  localparam int CNT_W = 16;

endpackage

// File: rtl/hiscore_delay_counter.sv
// hiscore_delay_counter: saturating up-counter with clear/load and a
// terminal flag that is high when one more increment reaches LIMIT.
module hiscore_delay_counter
  import hiscore_pkg::*;
#(
  parameter int W     = CNT_W,
  parameter int LIMIT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic         last
);

  localparam logic [W:0]   LIM  = (W+1)'(LIMIT);
  localparam logic [W:0]   ONEW = (W+1)'(1);
  localparam logic [W-1:0] STEP = W'(1);

  logic [W-1:0] count;

  // clear beats load, load beats increment; stop at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && (count != '1)) begin
      count <= count + STEP;
    end
  end

  // Lets the FSM leave on the same edge the count reaches LIMIT.
  assign last = (({1'b0, count} + ONEW) >= LIM);

endmodule

// File: rtl/hiscore_ram_arbiter.sv
// hiscore_ram_arbiter: pauses the game CPU and hands its RAM port to the
// hiscore engine. Optional watchdog: define HIGHSCORE_ARB_TIMEOUT_EN.
module hiscore_ram_arbiter
  import hiscore_pkg::*;
#(
  parameter int AW           = 10,
  parameter int PAUSE_SETTLE = DEF_PAUSE_SETTLE,
  parameter int LINGER       = DEF_LINGER,
  parameter int MAX_HOLD     = DEF_MAX_HOLD
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_dout,
  input  logic          cpu_wr,
  input  logic          cpu_safe,
  input  logic          hs_access,
  input  logic          hs_write,
  input  logic [AW-1:0] hs_addr,
  input  logic [7:0]    hs_data,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  output logic          cpu_pause,
  output logic          hs_grant,
  output logic          hs_timeout
);

  hs_state_e state;

  logic settle_last;
  logic linger_last;
  logic in_settle;
  logic in_grant;

  assign in_settle = (state == ST_SETTLE);
  assign in_grant  = (state == ST_GRANT);

  hiscore_delay_counter #(
    .W     (CNT_W),
    .LIMIT (PAUSE_SETTLE)
  ) u_settle (
    .clk      (clk),
    .reset    (reset),
    .clear    (!in_settle),
    .load     (1'b0),
    .load_val ('0),
    .inc      (in_settle),
    .last     (settle_last)
  );

  hiscore_delay_counter #(
    .W     (CNT_W),
    .LIMIT (LINGER)
  ) u_linger (
    .clk      (clk),
    .reset    (reset),
    .clear    (!in_grant || hs_access),
    .load     (1'b0),
    .load_val ('0),
    .inc      (in_grant && !hs_access),
    .last     (linger_last)
  );

`ifdef HIGHSCORE_ARB_TIMEOUT_EN
  logic hold_last;
  logic timeout_q;

  hiscore_delay_counter #(
    .W     (CNT_W),
    .LIMIT (MAX_HOLD)
  ) u_hold (
    .clk      (clk),
    .reset    (reset),
    .clear    (!in_grant || !hs_access),
    .load     (1'b0),
    .load_val ('0),
    .inc      (in_grant && hs_access),
    .last     (hold_last)
  );

  assign hs_timeout = timeout_q;
`else
  assign hs_timeout = 1'b0;
`endif

  // arbitration FSM; pause/grant are registered alongside the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cpu_pause <= 1'b0;
      hs_grant  <= 1'b0;
`ifdef HIGHSCORE_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (hs_access) begin
            state     <= ST_PAUSE_REQ;
            cpu_pause <= 1'b1;
          end
        end
        ST_PAUSE_REQ: begin
          if (cpu_safe) begin
            if (PAUSE_SETTLE == 0) begin
              state    <= ST_GRANT;
              hs_grant <= 1'b1;
            end else begin
              state <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_last) begin
            state    <= ST_GRANT;
            hs_grant <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (!hs_access && linger_last) begin
            state    <= ST_RELEASE;
            hs_grant <= 1'b0;
          end
`ifdef HIGHSCORE_ARB_TIMEOUT_EN
          else if (hs_access && hold_last) begin
            state     <= ST_RELEASE;
            hs_grant  <= 1'b0;
            timeout_q <= 1'b1;
          end
`endif
        end
        ST_RELEASE: begin
          state     <= ST_IDLE;
          cpu_pause <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          cpu_pause <= 1'b0;
          hs_grant  <= 1'b0;
        end
      endcase
    end
  end

  // RAM port mux; CPU writes are masked while it is being paused
  always_comb begin
    if (hs_grant) begin
      ram_addr = hs_addr;
      ram_din  = hs_data;
      ram_we   = hs_access & hs_write;
    end else begin
      ram_addr = cpu_addr;
      ram_din  = cpu_dout;
      ram_we   = cpu_wr & ~cpu_pause;
    end
  end

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// tb_hiscore_ram_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model of the arbitration rules.
module tb_hiscore_ram_arbiter;

  localparam int AW = 10;
  localparam int PS = 4;
  localparam int LG = 8;
  localparam int MH = 16;

  localparam int M_CPU    = 0;
  localparam int M_WAIT   = 1;
  localparam int M_SETTLE = 2;
  localparam int M_GRANT  = 3;
  localparam int M_REL    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_dout = '0;
  logic          cpu_wr = 1'b0;
  logic          cpu_safe = 1'b0;
  logic          hs_access = 1'b0;
  logic          hs_write = 1'b0;
  logic [AW-1:0] hs_addr = '0;
  logic [7:0]    hs_data = '0;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din;
  logic          ram_we;
  logic          cpu_pause;
  logic          hs_grant;
  logic          hs_timeout;

  int tests = 0;
  int fails = 0;

  int m_mode;
  int m_settled;
  int m_idle;
  int m_hold;
  bit m_to;

  hiscore_ram_arbiter #(
    .AW           (AW),
    .PAUSE_SETTLE (PS),
    .LINGER       (LG),
    .MAX_HOLD     (MH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_wr     (cpu_wr),
    .cpu_safe   (cpu_safe),
    .hs_access  (hs_access),
    .hs_write   (hs_write),
    .hs_addr    (hs_addr),
    .hs_data    (hs_data),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .cpu_pause  (cpu_pause),
    .hs_grant   (hs_grant),
    .hs_timeout (hs_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic void model_reset();
    m_mode    = M_CPU;
    m_settled = 0;
    m_idle    = 0;
    m_hold    = 0;
    m_to      = 1'b0;
  endfunction

  // Advance the model by one clock using the inputs seen at the edge.
  function automatic void model_step();
    case (m_mode)
      M_CPU: if (hs_access) m_mode = M_WAIT;
      M_WAIT: begin
        if (cpu_safe) begin
          m_settled = 0;
          m_idle    = 0;
          m_hold    = 0;
          m_mode    = (PS == 0) ? M_GRANT : M_SETTLE;
        end
      end
      M_SETTLE: begin
        m_settled++;
        if (m_settled >= PS) m_mode = M_GRANT;
      end
      M_GRANT: begin
        if (hs_access) begin
          m_idle = 0;
          m_hold++;
`ifdef HIGHSCORE_ARB_TIMEOUT_EN
          if (m_hold >= MH) begin
            m_mode = M_REL;
            m_to   = 1'b1;
          end
`endif
        end else begin
          m_hold = 0;
          m_idle++;
          if (m_idle >= LG) m_mode = M_REL;
        end
      end
      default: m_mode = M_CPU;
    endcase
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cpu_addr  = '0;
    cpu_dout  = '0;
    cpu_wr    = 1'b0;
    cpu_safe  = 1'b0;
    hs_access = 1'b0;
    hs_write  = 1'b0;
    hs_addr   = '0;
    hs_data   = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic reach_grant();
    int n;
    n = 0;
    hs_access = 1'b1;
    cpu_safe  = 1'b1;
    while (hs_grant !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    cpu_safe = 1'b0;
    tests++;
    if (hs_grant !== 1'b1) begin
      fails++;
      $display("FAIL reach_grant: hs_grant=%b after %0d cycles, required 1",
               hs_grant, n);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    cpu_wr   = 1'b1;
    cpu_addr = 10'h123;
    cpu_dout = 8'hA5;
    hs_access = 1'b1;
    hs_write = 1'b1;
    hs_addr  = 10'h3FF;
    hs_data  = 8'hFF;
    @(posedge clk);
    #1;
    tests++;
    if (cpu_pause !== 1'b0) begin
      fails++;
      $display("FAIL rst_pause: got %b want 0", cpu_pause);
    end
    tests++;
    if (hs_grant !== 1'b0) begin
      fails++;
      $display("FAIL rst_grant: got %b want 0", hs_grant);
    end
    tests++;
    if (hs_timeout !== 1'b0) begin
      fails++;
      $display("FAIL rst_timeout: got %b want 0", hs_timeout);
    end
    tests++;
    if (ram_we !== 1'b1 || ram_addr !== 10'h123 || ram_din !== 8'hA5) begin
      fails++;
      $display("FAIL rst_mux: we=%b addr=%h din=%h want 1/123/a5",
               ram_we, ram_addr, ram_din);
    end
    do_reset();
  endtask

  task automatic test_request();
    logic exp_g;
    do_reset();
    hs_access = 1'b1;
    #1;
    tests++;
    if (cpu_pause !== 1'b0) begin
      fails++;
      $display("FAIL req_pause_c0: got %b want 0", cpu_pause);
    end
    for (int c = 1; c <= 8; c++) begin
      tick();
      cpu_safe = (c == 3);
      #1;
      exp_g = (c >= 8);
      tests++;
      if (cpu_pause !== 1'b1) begin
        fails++;
        $display("FAIL req_pause c%0d: got %b want 1", c, cpu_pause);
      end
      tests++;
      if (hs_grant !== exp_g) begin
        fails++;
        $display("FAIL req_grant c%0d: got %b want %b", c, hs_grant, exp_g);
      end
    end
    cpu_safe = 1'b0;
  endtask

  task automatic test_write_through();
    hs_write = 1'b1;
    hs_addr  = 10'h30B;
    hs_data  = 8'h5A;
    cpu_wr   = 1'b1;
    cpu_addr = 10'h111;
    cpu_dout = 8'h22;
    #1;
    tests++;
    if (ram_addr !== 10'h30B || ram_din !== 8'h5A || ram_we !== 1'b1) begin
      fails++;
      $display("FAIL wr_through: addr=%h din=%h we=%b want 30b/5a/1",
               ram_addr, ram_din, ram_we);
    end
    hs_access = 1'b0;
    #1;
    tests++;
    if (ram_we !== 1'b0 || ram_addr !== 10'h30B) begin
      fails++;
      $display("FAIL wr_noaccess: we=%b addr=%h want 0/30b", ram_we, ram_addr);
    end
    hs_access = 1'b1;
    hs_write  = 1'b0;
    cpu_wr    = 1'b0;
  endtask

  task automatic test_linger();
    do_reset();
    reach_grant();
    for (int i = 0; i < 14; i++) begin
      hs_access = (i == 5);
      #1;
      tests++;
      if (hs_grant !== 1'b1 || cpu_pause !== 1'b1) begin
        fails++;
        $display("FAIL linger_hold i%0d: grant=%b pause=%b want 1/1",
                 i, hs_grant, cpu_pause);
      end
      tick();
    end
    hs_access = 1'b0;
    tests++;
    if (hs_grant !== 1'b0 || cpu_pause !== 1'b1) begin
      fails++;
      $display("FAIL linger_release: grant=%b pause=%b want 0/1",
               hs_grant, cpu_pause);
    end
    tick();
    tests++;
    if (hs_grant !== 1'b0 || cpu_pause !== 1'b0) begin
      fails++;
      $display("FAIL linger_idle: grant=%b pause=%b want 0/0",
               hs_grant, cpu_pause);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    reach_grant();
    tick();
    tick();
    #3;
    reset = 1'b1;
    #1;
    tests++;
    if (cpu_pause !== 1'b0 || hs_grant !== 1'b0 || hs_timeout !== 1'b0) begin
      fails++;
      $display("FAIL rst_async: pause=%b grant=%b to=%b want 0/0/0",
               cpu_pause, hs_grant, hs_timeout);
    end
    cpu_wr   = 1'b1;
    cpu_addr = 10'h010;
    #1;
    tests++;
    if (ram_we !== 1'b1 || ram_addr !== 10'h010) begin
      fails++;
      $display("FAIL rst_cpu_mux: we=%b addr=%h want 1/010", ram_we, ram_addr);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_inputs();
    model_reset();
  endtask

  task automatic test_timeout();
    do_reset();
    reach_grant();
`ifdef HIGHSCORE_ARB_TIMEOUT_EN
    for (int i = 0; i < MH; i++) begin
      tests++;
      if (hs_grant !== 1'b1) begin
        fails++;
        $display("FAIL to_hold i%0d: grant=%b want 1", i, hs_grant);
      end
      tick();
    end
    tests++;
    if (hs_grant !== 1'b0 || cpu_pause !== 1'b1 || hs_timeout !== 1'b1) begin
      fails++;
      $display("FAIL to_release: grant=%b pause=%b to=%b want 0/1/1",
               hs_grant, cpu_pause, hs_timeout);
    end
    tick();
    tick();
    tests++;
    if (hs_timeout !== 1'b1 || cpu_pause !== 1'b1) begin
      fails++;
      $display("FAIL to_sticky: to=%b pause=%b want 1/1", hs_timeout, cpu_pause);
    end
`else
    for (int i = 0; i < 3 * MH; i++) begin
      tests++;
      if (hs_grant !== 1'b1 || hs_timeout !== 1'b0) begin
        fails++;
        $display("FAIL to_off i%0d: grant=%b to=%b want 1/0",
                 i, hs_grant, hs_timeout);
      end
      tick();
    end
`endif
    hs_access = 1'b0;
  endtask

  task automatic test_late_request();
    do_reset();
    reach_grant();
    hs_access = 1'b0;
    for (int i = 0; i < LG; i++) tick();
    hs_access = 1'b1;
    hs_write  = 1'b1;
    cpu_wr    = 1'b0;
    #1;
    tests++;
    if (hs_grant !== 1'b0 || cpu_pause !== 1'b1 || ram_we !== 1'b0) begin
      fails++;
      $display("FAIL late_rel: grant=%b pause=%b we=%b want 0/1/0",
               hs_grant, cpu_pause, ram_we);
    end
    tick();
    tests++;
    if (hs_grant !== 1'b0 || cpu_pause !== 1'b0 || ram_we !== 1'b0) begin
      fails++;
      $display("FAIL late_idle: grant=%b pause=%b we=%b want 0/0/0",
               hs_grant, cpu_pause, ram_we);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (hs_grant !== 1'b0 || cpu_pause !== 1'b1) begin
        fails++;
        $display("FAIL late_pausereq i%0d: grant=%b pause=%b want 0/1",
                 i, hs_grant, cpu_pause);
      end
    end
    hs_write = 1'b0;
  endtask

  task automatic test_random();
    logic          e_pause;
    logic          e_grant;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_din;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) begin
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
      end
      if ($urandom_range(0, 5) == 0) hs_access = ~hs_access;
      cpu_safe = ($urandom_range(0, 3) == 0);
      hs_write = 1'($urandom);
      cpu_wr   = 1'($urandom);
      cpu_addr = AW'($urandom);
      hs_addr  = AW'($urandom);
      cpu_dout = 8'($urandom);
      hs_data  = 8'($urandom);
      #1;
      e_pause = (m_mode != M_CPU);
      e_grant = (m_mode == M_GRANT);
      e_addr  = e_grant ? hs_addr : cpu_addr;
      e_din   = e_grant ? hs_data : cpu_dout;
      e_we    = e_grant ? (hs_access & hs_write) : (cpu_wr & ~e_pause);
      tests++;
      if (cpu_pause !== e_pause) begin
        fails++;
        $display("FAIL rnd_pause cyc%0d: got %b want %b", i, cpu_pause, e_pause);
      end
      tests++;
      if (hs_grant !== e_grant) begin
        fails++;
        $display("FAIL rnd_grant cyc%0d: got %b want %b", i, hs_grant, e_grant);
      end
      tests++;
      if (hs_timeout !== m_to) begin
        fails++;
        $display("FAIL rnd_timeout cyc%0d: got %b want %b", i, hs_timeout, m_to);
      end
      tests++;
      if (ram_addr !== e_addr || ram_din !== e_din || ram_we !== e_we) begin
        fails++;
        $display("FAIL rnd_mux cyc%0d: addr=%h din=%h we=%b want %h/%h/%b",
                 i, ram_addr, ram_din, ram_we, e_addr, e_din, e_we);
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_request();
    test_write_through();
    test_linger();
    test_reset_mid_grant();
    test_timeout();
    test_late_request();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
